dom_keccak_chi_pipe: RTL and testbench
======================================

DOM_KECCAK_CHI_PIPE -- requirements
Module: dom_keccak_chi_pipe

Interface
REQ-001 SHALL have parameter ORDER, default 2, masking order d; share count S = ORDER+1.
REQ-002 SHALL have parameter ROWS, default 1, number of 5-bit chi rows processed in parallel; legal range 1..5.
REQ-003 SHALL have derived localparam W = 5*ROWS, the unmasked data width.
REQ-004 SHALL have derived localparam RW = W*S*(S-1)/2, the fresh-randomness bits per transaction.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1, input transaction valid.
REQ-008 SHALL have port in_ready, output, 1, block accepts the transaction this cycle.
REQ-009 SHALL have port chi_en, input, 1, sampled with the input; 1 = apply chi, 0 = pass shares through unchanged.
REQ-010 SHALL have port x_sh, input, W*S, input shares; share s, row r, bit b at index s*W + r*5 + b.
REQ-011 SHALL have port rnd, input, RW, fresh randomness; one bit per share pair (i<j) per output bit, pair-major then bit index.
REQ-012 SHALL have port out_valid, output, 1, output transaction valid.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts the output.
REQ-014 SHALL have port y_sh, output, W*S, output shares, same layout as x_sh.
REQ-015 SHALL have port busy, output, 1, high while either pipeline stage holds a transaction.

Function
REQ-016 SHALL compute per row, bit b: y[b] = x[b] XOR (NOT x[b+1] AND x[b+2]), indices mod 5 within the row.
REQ-017 SHALL implement masked NOT by inverting share 0 of operand x[b+1] only.
REQ-018 SHALL implement each AND as DOM-indep: inner term a_i&b_i for share i; cross term a_i&b_j XOR z for i!=j, the same z bit used for pairs (i,j) and (j,i).
REQ-019 SHALL register all inner and cross terms, plus a copy of x_sh and chi_en, in stage 1 before any cross-domain XOR compression.
REQ-020 SHALL compress in stage 2: y share i = x share i XOR inner_i XOR all cross terms (i,j); result registered onto y_sh.
REQ-021 SHALL have latency 2 cycles from accepted input to out_valid under no backpressure, throughput 1 transaction/cycle.
REQ-022 SHALL, with chi_en=0, output y_sh = registered x_sh, same latency, rnd ignored.
REQ-023 SHALL accept input when in_valid && in_ready; in_ready = !s1_valid || (s2 can load).
REQ-024 SHALL load stage 2 when s1_valid && (!out_valid || out_ready).
REQ-025 SHALL hold y_sh and out_valid stable while out_valid && !out_ready.
REQ-026 SHALL hold stage-1 registers unchanged while stalled; rnd sampled only on acceptance.
REQ-027 SHALL, on simultaneous output accept and stage-1 advance, move the new transaction into stage 2 in the same cycle without bubble.
REQ-028 SHALL NOT combine shares of different domains combinationally before the stage-1 register.
REQ-029 SHALL drive busy = s1_valid || out_valid.

Reset
REQ-030 SHALL, on rst assertion, clear s1_valid, out_valid and all data registers to 0 immediately, independent of clk.
REQ-031 SHALL drive in_ready=1, busy=0, y_sh=0 while rst is high and the first cycle after release.
REQ-032 SHALL discard any in-flight transaction when rst asserts mid-operation; no output produced for it.

Verification
REQ-033 ORDER=1, ROWS=1, chi_en=1, x unmasked 5'b00001 split into shares, out_ready=1 -> after 2 cycles XOR of y shares = 5'b01001.
REQ-034 ORDER=2, ROWS=5, 1000 random transactions, random rnd, continuous in_valid -> each unmasked output = chi(unmasked input), one result per cycle after 2-cycle fill.
REQ-035 chi_en=0, x shares arbitrary -> y_sh bit-identical to x_sh after 2 cycles.
REQ-036 out_ready held 0 for 4 cycles with stream in -> in_ready drops after 2 accepts, y_sh/out_valid stable, no loss or duplication on release.
REQ-037 rst pulsed with both stages full -> out_valid=0, busy=0, in_ready=1 asynchronously; next input yields correct result at latency 2.
REQ-038 Fixed unmasked input, varying shares and rnd -> unmasked output constant; any single share of y_sh not constant across runs.

Source files
------------

// File: rtl/dom_keccak_chi_pipe.sv
// Two-stage masked Keccak chi using domain-oriented masking (DOM-indep AND).
// Stage 1 registers all partial products, stage 2 compresses them per share domain.
module dom_keccak_chi_pipe #(
    parameter int ORDER = 2,
    parameter int ROWS  = 1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic                                         chi_en,
    input  logic [5*ROWS*(ORDER+1)-1:0]                  x_sh,
    input  logic [5*ROWS*(ORDER+1)*ORDER/2-1:0]          rnd,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [5*ROWS*(ORDER+1)-1:0]                  y_sh,
    output logic                                         busy
);

    localparam int S  = ORDER + 1;
    localparam int W  = 5 * ROWS;
    localparam int RW = W * S * (S - 1) / 2;

    logic           vld_p1, vld_p2;
    logic           chi_p1;
    logic           acc, load2;
    logic [W-1:0]   xs_c     [S];
    logic [W-1:0]   an_c     [S];
    logic [W-1:0]   bv_c     [S];
    logic [W-1:0]   inner_c  [S];
    logic [W-1:0]   cross_c  [S][S];
    logic [W-1:0]   x_p1     [S];
    logic [W-1:0]   inner_p1 [S];
    logic [W-1:0]   cross_p1 [S][S];
    logic [W-1:0]   part_c   [S][S+1];
    logic [W-1:0]   y_c      [S];
    logic [W*S-1:0] y_flat;
    logic [W*S-1:0] y_p2;

    assign load2     = vld_p1 && (!vld_p2 || out_ready);
    assign in_ready  = !vld_p1 || load2;
    assign acc       = in_valid && in_ready;
    assign out_valid = vld_p2;
    assign y_sh      = y_p2;
    assign busy      = vld_p1 || vld_p2;

    // Operand selection per share: a = NOT x[b+1] (only share 0 inverted), b = x[b+2].
    for (genvar i = 0; i < S; i++) begin : g_op
        assign xs_c[i] = x_sh[i*W +: W];
        for (genvar k = 0; k < W; k++) begin : g_bit
            localparam int R = k / 5;
            localparam int B = k % 5;
            assign an_c[i][k] = x_sh[i*W + R*5 + (B+1)%5] ^ (i == 0);
            assign bv_c[i][k] = x_sh[i*W + R*5 + (B+2)%5];
        end
        assign inner_c[i] = an_c[i] & bv_c[i];
    end

    // Cross-domain products are blinded by one fresh bit shared by pairs (i,j) and (j,i).
    for (genvar i = 0; i < S; i++) begin : g_cr_i
        for (genvar j = 0; j < S; j++) begin : g_cr_j
            localparam int LO = (i < j) ? i : j;
            localparam int HI = (i < j) ? j : i;
            localparam int P  = LO*S - (LO*(LO+1))/2 + (HI - LO - 1);
            if (i != j) begin : g_off
                assign cross_c[i][j] = (an_c[i] & bv_c[j]) ^ rnd[P*W +: W];
            end else begin : g_diag
                assign cross_c[i][j] = '0;
            end
        end
    end

    // ---- stage 1 register boundary ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            chi_p1   <= 1'b0;
            x_p1     <= '{default: '0};
            inner_p1 <= '{default: '0};
            cross_p1 <= '{default: '0};
        end else begin
            if (acc) begin
                vld_p1   <= 1'b1;
                chi_p1   <= chi_en;
                x_p1     <= xs_c;
                inner_p1 <= inner_c;
                cross_p1 <= cross_c;
            end else if (load2) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    // Per-domain compression: only registered terms are combined here.
    for (genvar i = 0; i < S; i++) begin : g_cmp
        assign part_c[i][0] = x_p1[i] ^ inner_p1[i];
        for (genvar j = 0; j < S; j++) begin : g_acc
            assign part_c[i][j+1] = part_c[i][j] ^ cross_p1[i][j];
        end
        assign y_c[i]              = chi_p1 ? part_c[i][S] : x_p1[i];
        assign y_flat[i*W +: W]    = y_c[i];
    end

    // ---- stage 2 register boundary ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2 <= 1'b0;
            y_p2   <= '0;
        end else begin
            if (load2) begin
                vld_p2 <= 1'b1;
                y_p2   <= y_flat;
            end else if (out_ready) begin
                vld_p2 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dom_keccak_chi_pipe.sv
// Scoreboard bench for dom_keccak_chi_pipe (ORDER=2, ROWS=5) against an unmasked chi model.
module tb_dom_keccak_chi_pipe;

    localparam int ORDER = 2;
    localparam int ROWS  = 5;
    localparam int S     = ORDER + 1;
    localparam int W     = 5 * ROWS;
    localparam int WS    = W * S;
    localparam int RW    = W * S * (S - 1) / 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          chi_en;
    logic [WS-1:0] x_sh;
    logic [RW-1:0] rnd;
    logic          out_valid;
    logic          out_ready;
    logic [WS-1:0] y_sh;
    logic          busy;

    typedef struct {
        bit            chi;
        logic [WS-1:0] sh;
        logic [W-1:0]  u;
        bit            fixed;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] fixed_sh0[$];
    int           npass = 0;
    int           ntot  = 0;
    int           miss  = 0;
    int           bp_mode = 0;

    dom_keccak_chi_pipe #(.ORDER(ORDER), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .chi_en(chi_en), .x_sh(x_sh), .rnd(rnd), .out_valid(out_valid),
        .out_ready(out_ready), .y_sh(y_sh), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] chi_ref(input logic [W-1:0] x);
        logic [W-1:0] y;
        for (int r = 0; r < ROWS; r++)
            for (int b = 0; b < 5; b++)
                y[r*5+b] = x[r*5+b] ^ (~x[r*5+(b+1)%5] & x[r*5+(b+2)%5]);
        return y;
    endfunction

    function automatic logic [W-1:0] unmask(input logic [WS-1:0] sh);
        logic [W-1:0] u = '0;
        for (int s = 0; s < S; s++) u ^= sh[s*W +: W];
        return u;
    endfunction

    function automatic logic [WS-1:0] rand_ws();
        logic [95:0] t = {$urandom(), $urandom(), $urandom()};
        return t[WS-1:0];
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [31:0] t = $urandom();
        return t[W-1:0];
    endfunction

    function automatic logic [WS-1:0] split(input logic [W-1:0] u);
        logic [WS-1:0] sh = rand_ws();
        sh[W-1:0] = sh[W-1:0] ^ unmask(sh) ^ u;
        return sh;
    endfunction

    task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
        ntot++;
        if (ok) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic try_once(input bit c, input logic [WS-1:0] x, input logic [RW-1:0] r,
                            input bit fx, output bit acc);
        exp_t e;
        in_valid = 1'b1; chi_en = c; x_sh = x; rnd = r;
        @(negedge clk);
        acc = in_ready;
        if (acc) begin
            e.chi = c; e.sh = x; e.u = chi_ref(unmask(x)); e.fixed = fx;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input bit c, input logic [WS-1:0] x, input logic [RW-1:0] r, input bit fx);
        bit acc = 1'b0;
        int n = 0;
        while (!acc && n < 200) begin
            try_once(c, x, r, fx, acc);
            if (!acc) miss++;
            n++;
        end
        if (!acc) chk(1'b0, "send_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk(sb.size() == 0 && !busy, "drain", sb.size(), 0);
    endtask

    // Downstream ready generator
    initial begin
        forever begin
            @(posedge clk); #1;
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every output handshake and checks stall stability.
    initial begin
        bit            stall_prev = 1'b0;
        logic [WS-1:0] prev_y = '0;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev)
                    chk(out_valid && y_sh == prev_y, "stall_hold", y_sh, prev_y);
                stall_prev = out_valid && !out_ready;
                prev_y     = y_sh;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk(1'b0, "spurious_out", y_sh, 0);
                    end else begin
                        e = sb.pop_front();
                        if (e.chi) chk(unmask(y_sh) == e.u, "chi_out", unmask(y_sh), e.u);
                        else       chk(y_sh == e.sh, "pass_out", y_sh, e.sh);
                        if (e.fixed) fixed_sh0.push_back(y_sh[W-1:0]);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] kin;
        logic [W-1:0] kexp;
        logic [W-1:0] fixu;
        bit           acc;
        bit           distinct;
        int           cnt;
        int           m0;

        kin  = {5{5'b00001}};
        kexp = {5{5'b01001}};
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; chi_en = 1'b0; x_sh = '0; rnd = '0;
        repeat (3) @(posedge clk);
        #1;
        chk(in_ready == 1'b1, "rst_in_ready", in_ready, 1);
        chk(busy == 1'b0, "rst_busy", busy, 0);
        chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
        chk(y_sh == '0, "rst_y_sh", y_sh, 0);
        rst = 1'b0;
        @(negedge clk);
        chk(in_ready && !busy && y_sh == '0, "post_rst_cycle", {in_ready, busy}, 2'b10);
        @(posedge clk); #1;

        // Directed chi of 00001 per row and 2-cycle latency
        send(1'b1, split(kin), rand_ws(), 1'b0);
        @(negedge clk);
        chk(out_valid == 1'b0, "lat_cycle1", out_valid, 0);
        @(negedge clk);
        chk(out_valid == 1'b1, "lat_cycle2", out_valid, 1);
        chk(unmask(y_sh) == kexp, "chi_00001", unmask(y_sh), kexp);
        @(posedge clk); #1;
        drain();

        // Continuous random stream, no backpressure
        m0 = miss;
        for (int t = 0; t < 1000; t++) send(1'b1, split(rand_w()), rand_ws(), 1'b0);
        chk(miss == m0, "throughput_stalls", miss - m0, 0);
        drain();

        // Pass-through mode
        for (int t = 0; t < 20; t++) send(1'b0, rand_ws(), rand_ws(), 1'b0);
        drain();

        // Fixed secret, fresh shares and randomness each run
        fixu = rand_w();
        for (int t = 0; t < 10; t++) send(1'b1, split(fixu), rand_ws(), 1'b1);
        drain();
        distinct = 1'b0;
        for (int i = 1; i < fixed_sh0.size(); i++)
            if (fixed_sh0[i] != fixed_sh0[0]) distinct = 1'b1;
        chk(distinct && fixed_sh0.size() == 10, "share0_varies", fixed_sh0.size(), 10);

        // Output stalled for 4 cycles while input keeps streaming
        bp_mode = 1; out_ready = 1'b0;
        cnt = 0;
        for (int t = 0; t < 4; t++) begin
            try_once(1'b1, split(rand_w()), rand_ws(), 1'b0, acc);
            if (acc) cnt++;
        end
        chk(cnt == 2, "stall_accepts", cnt, 2);
        chk(in_ready == 1'b0, "stall_in_ready", in_ready, 0);
        chk(busy == 1'b1, "stall_busy", busy, 1);
        bp_mode = 0; out_ready = 1'b1;
        drain();

        // Random backpressure, mixed modes
        bp_mode = 2;
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 3) == 0) send(1'b0, rand_ws(), rand_ws(), 1'b0);
            else                           send(1'b1, split(rand_w()), rand_ws(), 1'b0);
        end
        bp_mode = 0; out_ready = 1'b1;
        drain();

        // Asynchronous reset with both stages full
        bp_mode = 1; out_ready = 1'b0;
        for (int t = 0; t < 3; t++) try_once(1'b1, split(rand_w()), rand_ws(), 1'b0, acc);
        chk(busy && out_valid, "full_before_rst", {busy, out_valid}, 2'b11);
        #1 rst = 1'b1;
        #1;
        chk(out_valid == 1'b0, "arst_out_valid", out_valid, 0);
        chk(busy == 1'b0, "arst_busy", busy, 0);
        chk(in_ready == 1'b1, "arst_in_ready", in_ready, 1);
        chk(y_sh == '0, "arst_y_sh", y_sh, 0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0; bp_mode = 0; out_ready = 1'b1;
        send(1'b1, split(rand_w()), rand_ws(), 1'b0);
        @(negedge clk);
        chk(out_valid == 1'b0, "rst_lat_cycle1", out_valid, 0);
        @(negedge clk);
        chk(out_valid == 1'b1, "rst_lat_cycle2", out_valid, 1);
        @(posedge clk); #1;
        drain();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
